// File: rtl/counter_pkg.sv
// Shared types and parameter checks for the modulo counter chain and its consumers
// (e.g. the display decoder).
package counter_pkg;

    localparam int CNT_W = 8;

    typedef logic [CNT_W-1:0] stage_t;

    // A modulus is usable when it lies in 1 .. 2**width.
    function automatic bit modulus_ok(input int modulus, input int width);
        longint limit;
        limit = longint'(1) << width;
        return (modulus >= 1) && (longint'(modulus) <= limit);
    endfunction

endpackage

// File: rtl/counter_modulo_stage.sv
// One modulo-MOD up/down counter stage with saturating parallel load.
// at_term flags the value from which the next count in the current direction wraps.
module counter_modulo_stage #(
    parameter int W   = 8,
    parameter int MOD = 60
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         carry_in,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] cnt,
    output logic         at_term
);

    localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (load) begin
            // Out-of-range loads clamp so the stage never holds an illegal value.
            cnt_next = (load_value > MAX_VAL) ? MAX_VAL : load_value;
        end else if (carry_in) begin
            if (up) begin
                cnt_next = (cnt_reg == MAX_VAL) ? '0 : cnt_reg + W'(1);
            end else begin
                cnt_next = (cnt_reg == '0) ? MAX_VAL : cnt_reg - W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign at_term = up ? (cnt_reg == MAX_VAL) : (cnt_reg == '0);
    assign cnt     = cnt_reg;

endmodule

// File: rtl/counter_modulo_chain.sv
// Cascade of modulo counter stages (stage 0 least significant) with a combinational
// carry chain; tick[i] marks the cycle in which stage i wraps.
module counter_modulo_chain
    import counter_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int W          = 8,
    parameter int MODULI [NUM_STAGES-1:0] = '{24, 60, 60}
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             up,
    input  logic                             load,
    input  logic [NUM_STAGES-1:0][W-1:0]     load_value,
    output logic [NUM_STAGES-1:0][W-1:0]     cnt,
    output logic [NUM_STAGES-1:0]            tick,
    output logic                             tick_all
);

    logic [NUM_STAGES:0]   carry;
    logic [NUM_STAGES-1:0] at_term;

    // Reset and load both suppress counting, which also keeps every tick low.
    assign carry[0] = enable & ~load & ~reset;

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            if (!modulus_ok(MODULI[gi], W)) begin : g_bad_modulus
                $error("counter_modulo_chain: MODULI[%0d]=%0d outside 1..2**%0d",
                       gi, MODULI[gi], W);
            end

            counter_modulo_stage #(
                .W   (W),
                .MOD (MODULI[gi])
            ) u_stage (
                .clk        (clk),
                .reset      (reset),
                .carry_in   (carry[gi]),
                .up         (up),
                .load       (load),
                .load_value (load_value[gi]),
                .cnt        (cnt[gi]),
                .at_term    (at_term[gi])
            );

            assign carry[gi+1] = carry[gi] & at_term[gi];
        end
    endgenerate

    assign tick     = carry[NUM_STAGES:1];
    assign tick_all = tick[NUM_STAGES-1];

endmodule
